// File: rtl/fp_operand_sequencer_pkg.sv
// rtl/fp_operand_sequencer_pkg.sv - shared constants and state encoding for the FP operand sequencer
package fp_seq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR_CHK = 2'd1,
      PAYLOAD = 2'd2,
      ISSUE   = 2'd3
   } seq_state_t;

   localparam logic [3:0] SYNC_NIBBLE = 4'hA;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam int PKT_BYTES = 9;

endpackage

// File: rtl/fp_operand_sequencer_if.sv
// rtl/fp_operand_sequencer_if.sv - FIFO read port and FP-unit command handshake bundle
interface fp_operand_sequencer_if;

   logic        fifo_empty;
   logic [7:0]  fifo_data_out;
   logic        fifo_rd_en;
   logic        op_valid;
   logic        op_ready;
   logic [1:0]  op_code;
   logic [1:0]  rnd_mode;
   logic [31:0] op_a;
   logic [31:0] op_b;

   modport master (
      input  fifo_empty,
      input  fifo_data_out,
      output fifo_rd_en,
      output op_valid,
      input  op_ready,
      output op_code,
      output rnd_mode,
      output op_a,
      output op_b
   );

   modport slave (
      output fifo_empty,
      output fifo_data_out,
      input  fifo_rd_en,
      input  op_valid,
      output op_ready,
      input  op_code,
      input  rnd_mode,
      input  op_a,
      input  op_b
   );

endinterface

// File: rtl/fp_operand_sequencer.sv
// rtl/fp_operand_sequencer.sv - pops 9-byte packets from the FIFO and issues opcode/rounding/operand commands
module fp_operand_sequencer #(
   parameter logic [3:0] SYNC_NIBBLE   = 4'hA,
   parameter int         PAYLOAD_BYTES = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          enable,
   fp_operand_sequencer_if.master        bus,
   output logic                          pkt_err,
   output logic [7:0]                    pkt_count,
   output logic [1:0]                    seq_state
);

   import fp_seq_pkg::*;

   localparam logic [3:0] REQ_MAX  = 4'(PAYLOAD_BYTES);
   localparam logic [3:0] LAST_CAP = 4'(PAYLOAD_BYTES - 1);

   seq_state_t  state, state_nxt;
   logic [3:0]  req_cnt, cap_cnt;
   logic        rd_pend;
   logic        rd_en;
   logic        hdr_ok;
   logic        op_valid_q;
   logic [1:0]  op_code_q, rnd_mode_q;
   logic [31:0] op_a_q, op_b_q;

   assign hdr_ok = (bus.fifo_data_out[7:4] == SYNC_NIBBLE);

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      case (state)
         IDLE: begin
            rd_en = enable & ~bus.fifo_empty;
            if (rd_en) state_nxt = HDR_CHK;
         end
         HDR_CHK: begin
            state_nxt = hdr_ok ? PAYLOAD : IDLE;
         end
         PAYLOAD: begin
            rd_en = ~bus.fifo_empty & (req_cnt < REQ_MAX);
            if (rd_pend && (cap_cnt == LAST_CAP)) state_nxt = ISSUE;
         end
         ISSUE: begin
            if (op_valid_q && bus.op_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Gate with reset so the FIFO never sees a pop while the sequencer is held in reset
   assign bus.fifo_rd_en = rd_en & reset_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         req_cnt    <= 4'd0;
         cap_cnt    <= 4'd0;
         rd_pend    <= 1'b0;
         pkt_err    <= 1'b0;
         pkt_count  <= 8'd0;
         op_valid_q <= 1'b0;
         op_code_q  <= 2'b00;
         rnd_mode_q <= 2'b00;
         op_a_q     <= 32'd0;
         op_b_q     <= 32'd0;
      end else begin
         state   <= state_nxt;
         rd_pend <= rd_en;
         pkt_err <= 1'b0;
         case (state)
            HDR_CHK: begin
               if (hdr_ok) begin
                  op_code_q  <= bus.fifo_data_out[1:0];
                  rnd_mode_q <= bus.fifo_data_out[3:2];
                  req_cnt    <= 4'd0;
                  cap_cnt    <= 4'd0;
               end else begin
                  pkt_err <= 1'b1;
               end
            end
            PAYLOAD: begin
               if (rd_en && (req_cnt < REQ_MAX)) req_cnt <= req_cnt + 4'd1;
               if (rd_pend && (cap_cnt < REQ_MAX)) begin
                  case (cap_cnt)
                     4'd0:    op_a_q[31:24] <= bus.fifo_data_out;
                     4'd1:    op_a_q[23:16] <= bus.fifo_data_out;
                     4'd2:    op_a_q[15:8]  <= bus.fifo_data_out;
                     4'd3:    op_a_q[7:0]   <= bus.fifo_data_out;
                     4'd4:    op_b_q[31:24] <= bus.fifo_data_out;
                     4'd5:    op_b_q[23:16] <= bus.fifo_data_out;
                     4'd6:    op_b_q[15:8]  <= bus.fifo_data_out;
                     4'd7:    op_b_q[7:0]   <= bus.fifo_data_out;
                     default: ;
                  endcase
                  cap_cnt <= cap_cnt + 4'd1;
                  if (cap_cnt == LAST_CAP) op_valid_q <= 1'b1;
               end
            end
            ISSUE: begin
               if (op_valid_q && bus.op_ready) begin
                  op_valid_q <= 1'b0;
                  pkt_count  <= pkt_count + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.op_valid = op_valid_q;
   assign bus.op_code  = op_code_q;
   assign bus.rnd_mode = rnd_mode_q;
   assign bus.op_a     = op_a_q;
   assign bus.op_b     = op_b_q;
   assign seq_state    = state;

endmodule

// File: tb/tb_fp_operand_sequencer.sv
// tb/tb_fp_operand_sequencer.sv - directed self-checking bench for fp_operand_sequencer
module tb_fp_operand_sequencer;
   import fp_seq_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable;
   logic       pkt_err;
   logic [7:0] pkt_count;
   logic [1:0] seq_state;

   fp_operand_sequencer_if bus();

   fp_operand_sequencer dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .bus       (bus),
      .pkt_err   (pkt_err),
      .pkt_count (pkt_count),
      .seq_state (seq_state)
   );

   always #5 clk = ~clk;

   // FIFO model: data appears the cycle after an accepted read
   logic [7:0] mem [0:255];
   int wr_ptr = 0;
   int rd_ptr = 0;

   assign bus.fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
         bus.fifo_data_out <= mem[rd_ptr % 256];
         rd_ptr            <= rd_ptr + 1;
      end
   end

   int          viol      = 0;
   int          valid_cnt = 0;
   int          err_cnt   = 0;
   logic [31:0] last_a, last_b;
   logic [1:0]  last_code, last_rnd;

   always @(negedge clk) begin
      #2;
      if (bus.fifo_rd_en && bus.fifo_empty) viol++;
      if (pkt_err) err_cnt++;
      if (bus.op_valid) begin
         valid_cnt++;
         last_a    = bus.op_a;
         last_b    = bus.op_b;
         last_code = bus.op_code;
         last_rnd  = bus.rnd_mode;
      end
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr % 256] = b;
      wr_ptr++;
   endtask

   task automatic push_pkt(input logic [7:0] hdr, input logic [31:0] a, input logic [31:0] b);
      push(hdr);
      push(a[31:24]); push(a[23:16]); push(a[15:8]); push(a[7:0]);
      push(b[31:24]); push(b[23:16]); push(b[15:8]); push(b[7:0]);
   endtask

   task automatic wait_valid(input int prev, input int budget);
      int n = 0;
      while (valid_cnt <= prev && n < budget) begin
         @(negedge clk);
         #3;
         n++;
      end
      chk("valid_timeout", 32'(valid_cnt > prev), 32'd1);
   endtask

   logic [7:0] starve_bytes [0:8] = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

   initial begin
      logic [15:0] rd_bits, valid_bits, err_bits;
      int prev, prev_err;

      reset_n     = 1'b0;
      enable      = 1'b1;
      bus.op_ready = 1'b1;
      push_pkt(8'hA0, 32'h3F800000, 32'h40000000);
      repeat (3) @(negedge clk);
      #1;
      chk("rst_rd_en", bus.fifo_rd_en, 0);
      chk("rst_valid", bus.op_valid, 0);
      chk("rst_op_a", bus.op_a, 0);
      chk("rst_op_b", bus.op_b, 0);
      chk("rst_code", bus.op_code, 0);
      chk("rst_rnd", bus.rnd_mode, 0);
      chk("rst_err", pkt_err, 0);
      chk("rst_count", pkt_count, 0);
      chk("rst_state", seq_state, 0);

      // Nominal packet, cycle 0 is the first cycle after reset release
      @(negedge clk);
      reset_n    = 1'b1;
      rd_bits    = '0;
      valid_bits = '0;
      for (int k = 0; k < 14; k++) begin
         #1;
         rd_bits[k]    = bus.fifo_rd_en;
         valid_bits[k] = bus.op_valid;
         @(negedge clk);
      end
      chk("nom_rd_pattern", rd_bits, 16'h03FD);
      chk("nom_valid_pattern", valid_bits, 16'h0800);
      chk("nom_op_a", last_a, 32'h3F800000);
      chk("nom_op_b", last_b, 32'h40000000);
      chk("nom_code", last_code, OP_ADD);
      chk("nom_rnd", last_rnd, 2'b00);
      chk("nom_count", pkt_count, 1);

      // Backpressure: hold op_ready low for 5 valid cycles
      bus.op_ready = 1'b0;
      prev = valid_cnt;
      push_pkt(8'hA6, 32'hC0490FDB, 32'h3F000000);
      wait_valid(prev, 30);
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", bus.op_valid, 1);
         chk("bp_op_a", bus.op_a, 32'hC0490FDB);
         chk("bp_op_b", bus.op_b, 32'h3F000000);
         chk("bp_code", bus.op_code, OP_MUL);
         chk("bp_rnd", bus.rnd_mode, 2'b01);
         chk("bp_count_hold", pkt_count, 1);
         @(negedge clk);
         #3;
      end
      bus.op_ready = 1'b1;
      @(negedge clk);
      #3;
      chk("bp_valid_drop", bus.op_valid, 0);
      chk("bp_count", pkt_count, 2);

      // Bad header byte followed by a valid packet
      @(negedge clk);
      prev_err = err_cnt;
      push(8'h50);
      push_pkt(8'hAB, 32'h41200000, 32'hC1A00000);
      rd_bits    = '0;
      err_bits   = '0;
      valid_bits = '0;
      for (int k = 0; k < 16; k++) begin
         #1;
         rd_bits[k]    = bus.fifo_rd_en;
         err_bits[k]   = pkt_err;
         valid_bits[k] = bus.op_valid;
         @(negedge clk);
      end
      chk("bad_rd_pattern", rd_bits, 16'h0FF5);
      chk("bad_err_pattern", err_bits, 16'h0004);
      chk("bad_valid_pattern", valid_bits, 16'h2000);
      chk("bad_err_count", err_cnt - prev_err, 1);
      chk("bad_op_a", last_a, 32'h41200000);
      chk("bad_op_b", last_b, 32'hC1A00000);
      chk("bad_code", last_code, OP_DIV);
      chk("bad_rnd", last_rnd, 2'b10);
      chk("bad_count", pkt_count, 3);

      // Starvation: one byte every 3 cycles
      prev = valid_cnt;
      for (int i = 0; i < 9; i++) begin
         if (i == 8) chk("starve_early_valid", valid_cnt - prev, 0);
         push(starve_bytes[i]);
         repeat (3) @(negedge clk);
      end
      wait_valid(prev, 20);
      chk("starve_valid_cycles", valid_cnt - prev, 1);
      chk("starve_op_a", last_a, 32'h12345678);
      chk("starve_op_b", last_b, 32'h9ABCDEF0);
      chk("starve_code", last_code, OP_SUB);
      chk("starve_rnd", last_rnd, 2'b01);
      @(negedge clk);
      #3;
      chk("starve_count", pkt_count, 4);
      chk("starve_no_empty_read", viol, 0);

      // Async reset in PAYLOAD after 3 operand bytes
      @(negedge clk);
      push(8'hA2); push(8'hFF); push(8'hFF); push(8'hFF);
      repeat (8) @(negedge clk);
      #1;
      chk("mid_state", seq_state, 2);
      chk("mid_op_a", bus.op_a, 32'hFFFFFF78);
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_op_a", bus.op_a, 0);
      chk("arst_op_b", bus.op_b, 0);
      chk("arst_valid", bus.op_valid, 0);
      chk("arst_state", seq_state, 0);
      chk("arst_count", pkt_count, 0);
      chk("arst_rd_en", bus.fifo_rd_en, 0);
      @(negedge clk);
      reset_n = 1'b1;
      prev = valid_cnt;
      push_pkt(8'hA2, 32'h40490FDB, 32'h3FC00000);
      wait_valid(prev, 30);
      chk("fresh_op_a", last_a, 32'h40490FDB);
      chk("fresh_op_b", last_b, 32'h3FC00000);
      chk("fresh_code", last_code, OP_MUL);
      chk("fresh_rnd", last_rnd, 2'b00);
      @(negedge clk);
      #3;
      chk("fresh_count", pkt_count, 1);
      chk("final_no_empty_read", viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
